// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Opcode/funct values, control encodings and the control
//                bundle shared by the ID-stage decoder and pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   localparam logic [5:0] c_op_rtype = 6'b000000;
   localparam logic [5:0] c_op_j     = 6'b000010;
   localparam logic [5:0] c_op_jal   = 6'b000011;
   localparam logic [5:0] c_op_addi  = 6'b001000;
   localparam logic [5:0] c_op_beq   = 6'b001010;
   localparam logic [5:0] c_op_bne   = 6'b001011;
   localparam logic [5:0] c_op_bnez  = 6'b001100;
   localparam logic [5:0] c_op_bgez  = 6'b001101;
   localparam logic [5:0] c_op_blt   = 6'b001110;
   localparam logic [5:0] c_op_lw    = 6'b101100;
   localparam logic [5:0] c_op_sw    = 6'b101101;
   localparam logic [5:0] c_fn_jr    = 6'b001000;

   localparam logic [2:0] c_aluop_add   = 3'b000;
   localparam logic [2:0] c_aluop_sub   = 3'b001;
   localparam logic [2:0] c_aluop_rtype = 3'b010;
   localparam logic [2:0] c_aluop_gez   = 3'b011;
   localparam logic [2:0] c_aluop_addi  = 3'b100;
   localparam logic [2:0] c_aluop_lt    = 3'b101;
   localparam logic [2:0] c_aluop_ne    = 3'b110;

   localparam logic [1:0] c_bt_eq  = 2'b00;
   localparam logic [1:0] c_bt_ne  = 2'b01;
   localparam logic [1:0] c_bt_lt  = 2'b10;
   localparam logic [1:0] c_bt_gez = 2'b11;

   localparam logic [1:0] c_regdst_rt = 2'b00;
   localparam logic [1:0] c_regdst_rd = 2'b01;
   localparam logic [1:0] c_regdst_ra = 2'b10;

   localparam logic [1:0] c_mtr_alu = 2'b00;
   localparam logic [1:0] c_mtr_mem = 2'b01;
   localparam logic [1:0] c_mtr_pc  = 2'b10;

   typedef struct packed {
      logic       regwrite;
      logic [2:0] aluop;
      logic       alusrc;
      logic [1:0] regdst;
      logic       branch;
      logic [1:0] branchtype;
      logic       memwrite;
      logic       memread;
      logic [1:0] memtoreg;
      logic       jump;
      logic       jr;
   } ctrl_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/id_ctrl_dec.sv
`default_nettype none
// ============================================================================
//  Module      : id_ctrl_dec
//  Description : Combinational opcode/funct decoder producing the control
//                bundle, source-register usage and the illegal flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ctrl_dec
   import cpu_pkg::*;
(
   input  logic [5:0] i_op,
   input  logic [5:0] i_fn,
   output ctrl_t      o_ctrl,
   output logic       o_uses_rs,
   output logic       o_uses_rt,
   output logic       o_illegal
);

   always_comb begin
      o_ctrl    = '0;
      o_uses_rs = 1'b0;
      o_uses_rt = 1'b0;
      o_illegal = 1'b0;
      case (i_op)
         c_op_rtype: begin
            o_uses_rs = 1'b1;
            if (i_fn == c_fn_jr) begin
               o_ctrl.jump = 1'b1;
               o_ctrl.jr   = 1'b1;
            end else begin
               o_uses_rt       = 1'b1;
               o_ctrl.regwrite = 1'b1;
               o_ctrl.aluop    = c_aluop_rtype;
               o_ctrl.regdst   = c_regdst_rd;
            end
         end
         c_op_addi: begin
            o_uses_rs       = 1'b1;
            o_ctrl.regwrite = 1'b1;
            o_ctrl.aluop    = c_aluop_addi;
            o_ctrl.alusrc   = 1'b1;
         end
         c_op_lw: begin
            o_uses_rs       = 1'b1;
            o_ctrl.regwrite = 1'b1;
            o_ctrl.aluop    = c_aluop_add;
            o_ctrl.alusrc   = 1'b1;
            o_ctrl.memread  = 1'b1;
            o_ctrl.memtoreg = c_mtr_mem;
         end
         c_op_sw: begin
            o_uses_rs       = 1'b1;
            o_uses_rt       = 1'b1;
            o_ctrl.alusrc   = 1'b1;
            o_ctrl.memwrite = 1'b1;
         end
         c_op_beq: begin
            o_uses_rs         = 1'b1;
            o_uses_rt         = 1'b1;
            o_ctrl.aluop      = c_aluop_sub;
            o_ctrl.branch     = 1'b1;
            o_ctrl.branchtype = c_bt_eq;
         end
         c_op_bne, c_op_bnez: begin
            o_uses_rs         = 1'b1;
            // bnez compares rs against zero, so its rt field is don't-care
            o_uses_rt         = (i_op == c_op_bne);
            o_ctrl.aluop      = c_aluop_ne;
            o_ctrl.branch     = 1'b1;
            o_ctrl.branchtype = c_bt_ne;
         end
         c_op_j: begin
            o_ctrl.jump = 1'b1;
         end
         c_op_jal: begin
            o_ctrl.regwrite = 1'b1;
            o_ctrl.regdst   = c_regdst_ra;
            o_ctrl.memtoreg = c_mtr_pc;
            o_ctrl.jump     = 1'b1;
         end
         c_op_blt: begin
            o_uses_rs         = 1'b1;
            o_uses_rt         = 1'b1;
            o_ctrl.aluop      = c_aluop_lt;
            o_ctrl.branch     = 1'b1;
            o_ctrl.branchtype = c_bt_lt;
         end
         c_op_bgez: begin
            o_uses_rs         = 1'b1;
            o_ctrl.aluop      = c_aluop_gez;
            o_ctrl.branch     = 1'b1;
            o_ctrl.branchtype = c_bt_gez;
         end
         default: begin
            o_illegal = 1'b1;
         end
      endcase
   end

endmodule : id_ctrl_dec
`default_nettype wire

// File: rtl/id_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage_ctrl
//  Description : ID stage control - decode, load-use stall, flush, ID/EX reg.
//                Define ID_STAGE_PERF_CNT_EN to add stall/flush counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_stage_ctrl
   import cpu_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int REG_AW   = 5,
   parameter int ALUOP_W  = 3,
   parameter int SIGN_EXT = 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [DATA_W-1:0]   instr_i,
   input  logic                ifid_valid_i,
   input  logic                flush_i,
   input  logic                ex_memread_i,
   input  logic [REG_AW-1:0]   ex_rt_i,
   output logic                pc_write_o,
   output logic                ifid_write_o,
   output logic                ex_valid_o,
   output logic                ex_regwrite_o,
   output logic                ex_alusrc_o,
   output logic                ex_branch_o,
   output logic                ex_memwrite_o,
   output logic                ex_memread_o,
   output logic                ex_jump_o,
   output logic                ex_jr_o,
   output logic [ALUOP_W-1:0]  ex_aluop_o,
   output logic [1:0]          ex_regdst_o,
   output logic [1:0]          ex_branchtype_o,
   output logic [1:0]          ex_memtoreg_o,
   output logic [REG_AW-1:0]   ex_rs_o,
   output logic [REG_AW-1:0]   ex_rt_o,
   output logic [REG_AW-1:0]   ex_rd_o,
   output logic [DATA_W-1:0]   ex_imm_o,
   output logic                ex_illegal_o
`ifdef ID_STAGE_PERF_CNT_EN
   ,
   output logic [31:0]         stall_cnt_o,
   output logic [31:0]         flush_cnt_o
`endif
);

   ctrl_t               w_ctrl;
   logic                w_uses_rs;
   logic                w_uses_rt;
   logic                w_illegal;
   logic [REG_AW-1:0]   w_rs;
   logic [REG_AW-1:0]   w_rt;
   logic [REG_AW-1:0]   w_rd;
   logic [DATA_W-1:0]   w_imm;
   logic                w_hazard;
   logic                w_bubble;

   ctrl_t               r_ctrl;
   logic                r_valid;
   logic                r_illegal;
   logic [REG_AW-1:0]   r_rs;
   logic [REG_AW-1:0]   r_rt;
   logic [REG_AW-1:0]   r_rd;
   logic [DATA_W-1:0]   r_imm;

   assign w_rs = instr_i[21 +: REG_AW];
   assign w_rt = instr_i[16 +: REG_AW];
   assign w_rd = instr_i[11 +: REG_AW];

   generate
      if (SIGN_EXT != 0) begin : g_sign_ext
         assign w_imm = {{(DATA_W-16){instr_i[15]}}, instr_i[15:0]};
      end else begin : g_zero_ext
         assign w_imm = {{(DATA_W-16){1'b0}}, instr_i[15:0]};
      end
   endgenerate

   id_ctrl_dec u_dec (
      .i_op      (instr_i[31:26]),
      .i_fn      (instr_i[5:0]),
      .o_ctrl    (w_ctrl),
      .o_uses_rs (w_uses_rs),
      .o_uses_rt (w_uses_rt),
      .o_illegal (w_illegal)
   );

   // $zero never carries a pending load result, so it cannot cause a stall
   assign w_hazard = ifid_valid_i & ex_memread_i & (ex_rt_i != '0) &
                     ((w_uses_rs & (w_rs == ex_rt_i)) |
                      (w_uses_rt & (w_rt == ex_rt_i)));

   assign w_bubble = flush_i | w_hazard | ~ifid_valid_i;

   // A flush must let IF take the redirect even when a stall is pending
   assign pc_write_o   = ~rst_i | flush_i | ~w_hazard;
   assign ifid_write_o = ~rst_i | flush_i | ~w_hazard;

   always_ff @(posedge clk_i) begin
      if (!rst_i || w_bubble) begin
         r_valid   <= 1'b0;
         r_ctrl    <= '0;
         r_illegal <= 1'b0;
         r_rs      <= '0;
         r_rt      <= '0;
         r_rd      <= '0;
         r_imm     <= '0;
      end else begin
         r_valid   <= 1'b1;
         r_ctrl    <= w_ctrl;
         r_illegal <= w_illegal;
         r_rs      <= w_rs;
         r_rt      <= w_rt;
         r_rd      <= w_rd;
         r_imm     <= w_imm;
      end
   end

   assign ex_valid_o      = r_valid;
   assign ex_regwrite_o   = r_ctrl.regwrite;
   assign ex_alusrc_o     = r_ctrl.alusrc;
   assign ex_branch_o     = r_ctrl.branch;
   assign ex_memwrite_o   = r_ctrl.memwrite;
   assign ex_memread_o    = r_ctrl.memread;
   assign ex_jump_o       = r_ctrl.jump;
   assign ex_jr_o         = r_ctrl.jr;
   assign ex_aluop_o      = ALUOP_W'(r_ctrl.aluop);
   assign ex_regdst_o     = r_ctrl.regdst;
   assign ex_branchtype_o = r_ctrl.branchtype;
   assign ex_memtoreg_o   = r_ctrl.memtoreg;
   assign ex_rs_o         = r_rs;
   assign ex_rt_o         = r_rt;
   assign ex_rd_o         = r_rd;
   assign ex_imm_o        = r_imm;
   assign ex_illegal_o    = r_illegal;

`ifdef ID_STAGE_PERF_CNT_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_hazard && !flush_i && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 32'd1;
         if (flush_i && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + 32'd1;
      end
   end

   assign stall_cnt_o = r_stall_cnt;
   assign flush_cnt_o = r_flush_cnt;
`endif

endmodule : id_stage_ctrl
`default_nettype wire

// File: tb/tb_id_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_stage_ctrl
//  Description : Self-checking bench for id_stage_ctrl: vector table, reset
//                and counter sequences, then random stimulus vs a model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage_ctrl;

   logic        clk;
   logic        rst;
   logic [31:0] instr;
   logic        ifid_valid;
   logic        flush;
   logic        ex_memread;
   logic [4:0]  ex_rt;

   logic        pc_write, ifid_write, ex_valid;
   logic        ex_regwrite, ex_alusrc, ex_branch, ex_memwrite, ex_memread_q;
   logic        ex_jump, ex_jr, ex_illegal;
   logic [2:0]  ex_aluop;
   logic [1:0]  ex_regdst, ex_branchtype, ex_memtoreg;
   logic [4:0]  ex_rs_q, ex_rt_q, ex_rd_q;
   logic [31:0] ex_imm;
`ifdef ID_STAGE_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   int checks = 0;
   int errors = 0;

   id_stage_ctrl dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .instr_i         (instr),
      .ifid_valid_i    (ifid_valid),
      .flush_i         (flush),
      .ex_memread_i    (ex_memread),
      .ex_rt_i         (ex_rt),
      .pc_write_o      (pc_write),
      .ifid_write_o    (ifid_write),
      .ex_valid_o      (ex_valid),
      .ex_regwrite_o   (ex_regwrite),
      .ex_alusrc_o     (ex_alusrc),
      .ex_branch_o     (ex_branch),
      .ex_memwrite_o   (ex_memwrite),
      .ex_memread_o    (ex_memread_q),
      .ex_jump_o       (ex_jump),
      .ex_jr_o         (ex_jr),
      .ex_aluop_o      (ex_aluop),
      .ex_regdst_o     (ex_regdst),
      .ex_branchtype_o (ex_branchtype),
      .ex_memtoreg_o   (ex_memtoreg),
      .ex_rs_o         (ex_rs_q),
      .ex_rt_o         (ex_rt_q),
      .ex_rd_o         (ex_rd_q),
      .ex_imm_o        (ex_imm),
      .ex_illegal_o    (ex_illegal)
`ifdef ID_STAGE_PERF_CNT_EN
      ,
      .stall_cnt_o     (stall_cnt),
      .flush_cnt_o     (flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Control word order: regwrite aluop alusrc regdst branch btype memwrite memread memtoreg jump jr
   localparam logic [15:0] c_jr   = 16'b0_000_0_00_0_00_0_0_00_1_1;
   localparam logic [15:0] c_rt   = 16'b1_010_0_01_0_00_0_0_00_0_0;
   localparam logic [15:0] c_addi = 16'b1_100_1_00_0_00_0_0_00_0_0;
   localparam logic [15:0] c_lw   = 16'b1_000_1_00_0_00_0_1_01_0_0;
   localparam logic [15:0] c_sw   = 16'b0_000_1_00_0_00_1_0_00_0_0;
   localparam logic [15:0] c_beq  = 16'b0_001_0_00_1_00_0_0_00_0_0;
   localparam logic [15:0] c_bne  = 16'b0_110_0_00_1_01_0_0_00_0_0;
   localparam logic [15:0] c_j    = 16'b0_000_0_00_0_00_0_0_00_1_0;
   localparam logic [15:0] c_jal  = 16'b1_000_0_10_0_00_0_0_10_1_0;
   localparam logic [15:0] c_blt  = 16'b0_101_0_00_1_10_0_0_00_0_0;
   localparam logic [15:0] c_bgez = 16'b0_011_0_00_1_11_0_0_00_0_0;

   typedef struct {
      string       name;
      logic [31:0] ins;
      logic        v, fl, mr;
      logic [4:0]  er;
      logic        pcw, ifw, val;
      logic [15:0] ctrl;
      logic        ill;
   } vec_t;

   typedef struct {
      logic        pcw, ifw, val;
      logic [15:0] ctrl;
      logic        ill;
   } exp_t;

   vec_t vecs[$];

   function automatic logic [31:0] mkr(input int rs, input int rt, input int rd, input logic [5:0] fn);
      return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, fn};
   endfunction

   function automatic logic [31:0] mki(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
      return {op, 5'(rs), 5'(rt), imm};
   endfunction

   function automatic logic [15:0] got_ctrl();
      return {ex_regwrite, ex_aluop, ex_alusrc, ex_regdst, ex_branch, ex_branchtype,
              ex_memwrite, ex_memread_q, ex_memtoreg, ex_jump, ex_jr};
   endfunction

   // Reference: table lookup plus the stall/flush/bubble rules
   function automatic exp_t model(input logic [31:0] ins, input logic v, input logic fl,
                                  input logic mr, input logic [4:0] er);
      exp_t        m;
      logic [5:0]  op = ins[31:26];
      logic [5:0]  fn = ins[5:0];
      logic [4:0]  rs = ins[25:21];
      logic [4:0]  rt = ins[20:16];
      logic [15:0] row;
      logic        known, urs, urt, hz, bub;
      case (op)
         6'h00:   row = (fn == 6'h08) ? c_jr : c_rt;
         6'h08:   row = c_addi;
         6'h2C:   row = c_lw;
         6'h2D:   row = c_sw;
         6'h0A:   row = c_beq;
         6'h0B:   row = c_bne;
         6'h0C:   row = c_bne;
         6'h02:   row = c_j;
         6'h03:   row = c_jal;
         6'h0E:   row = c_blt;
         6'h0D:   row = c_bgez;
         default: row = 16'h0000;
      endcase
      known = op inside {6'h00, 6'h08, 6'h2C, 6'h2D, 6'h0A, 6'h0B, 6'h0C, 6'h02, 6'h03, 6'h0E, 6'h0D};
      urs   = op inside {6'h00, 6'h08, 6'h2C, 6'h2D, 6'h0A, 6'h0B, 6'h0C, 6'h0E, 6'h0D};
      urt   = (op == 6'h00 && fn != 6'h08) || (op inside {6'h2D, 6'h0A, 6'h0B, 6'h0E});
      hz    = v && mr && (er != 0) && ((urs && rs == er) || (urt && rt == er));
      bub   = fl || hz || !v;
      m.pcw  = fl || !hz;
      m.ifw  = fl || !hz;
      m.val  = !bub;
      m.ctrl = bub ? 16'h0000 : row;
      m.ill  = bub ? 1'b0 : !known;
      return m;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive_check(input string nm, input logic [31:0] ins, input logic v, input logic fl,
                              input logic mr, input logic [4:0] er, input logic e_pcw,
                              input logic e_ifw, input logic e_val, input logic [15:0] e_ctrl,
                              input logic e_ill);
      @(negedge clk);
      rst = 1'b1; instr = ins; ifid_valid = v; flush = fl; ex_memread = mr; ex_rt = er;
      #2;
      chk({nm, ".pc_write"},   32'(pc_write),   32'(e_pcw));
      chk({nm, ".ifid_write"}, 32'(ifid_write), 32'(e_ifw));
      @(posedge clk);
      #1;
      chk({nm, ".valid"},   32'(ex_valid),   32'(e_val));
      chk({nm, ".ctrl"},    32'(got_ctrl()), 32'(e_ctrl));
      chk({nm, ".illegal"}, 32'(ex_illegal), 32'(e_ill));
      chk({nm, ".rs"},  32'(ex_rs_q), e_val ? 32'(ins[25:21]) : 32'd0);
      chk({nm, ".rt"},  32'(ex_rt_q), e_val ? 32'(ins[20:16]) : 32'd0);
      chk({nm, ".rd"},  32'(ex_rd_q), e_val ? 32'(ins[15:11]) : 32'd0);
      chk({nm, ".imm"}, ex_imm,       e_val ? 32'($signed(ins[15:0])) : 32'd0);
   endtask

   task automatic add(input string nm, input logic [31:0] ins, input logic v, input logic fl,
                      input logic mr, input int er, input logic pcw, input logic ifw,
                      input logic val, input logic [15:0] ctrl, input logic ill);
      vec_t t;
      t.name = nm; t.ins = ins; t.v = v; t.fl = fl; t.mr = mr; t.er = 5'(er);
      t.pcw = pcw; t.ifw = ifw; t.val = val; t.ctrl = ctrl; t.ill = ill;
      vecs.push_back(t);
   endtask

   initial begin
      logic [5:0]  ops [12];
      logic [31:0] ins;
      logic [5:0]  op, fn;
      int          rs, rt, sel;
      logic [4:0]  er;
      logic        v, fl, mr;
      exp_t        m;

      rst = 1'b0; instr = '0; ifid_valid = 1'b0; flush = 1'b0; ex_memread = 1'b0; ex_rt = '0;

      // Decode sweep, load-use and corner rows
      add("jr",    mkr(9, 0, 0, 6'h08),           1, 0, 0, 0, 1, 1, 1, c_jr,   0);
      add("add",   mkr(10, 11, 12, 6'h20),        1, 0, 0, 0, 1, 1, 1, c_rt,   0);
      add("addi",  mki(6'h08, 3, 4, 16'h8005),    1, 0, 0, 0, 1, 1, 1, c_addi, 0);
      add("lw",    mki(6'h2C, 5, 6, 16'h0010),    1, 0, 0, 0, 1, 1, 1, c_lw,   0);
      add("sw",    mki(6'h2D, 5, 6, 16'hFFFC),    1, 0, 0, 0, 1, 1, 1, c_sw,   0);
      add("beq",   mki(6'h0A, 1, 2, 16'h0003),    1, 0, 0, 0, 1, 1, 1, c_beq,  0);
      add("bne",   mki(6'h0B, 1, 2, 16'hFFF0),    1, 0, 0, 0, 1, 1, 1, c_bne,  0);
      add("bnez",  mki(6'h0C, 7, 0, 16'h0040),    1, 0, 0, 0, 1, 1, 1, c_bne,  0);
      add("j",     mki(6'h02, 31, 31, 16'hABCD),  1, 0, 0, 0, 1, 1, 1, c_j,    0);
      add("jal",   mki(6'h03, 0, 1, 16'h1234),    1, 0, 0, 0, 1, 1, 1, c_jal,  0);
      add("blt",   mki(6'h0E, 2, 3, 16'h0008),    1, 0, 0, 0, 1, 1, 1, c_blt,  0);
      add("bgez",  mki(6'h0D, 4, 0, 16'h8000),    1, 0, 0, 0, 1, 1, 1, c_bgez, 0);
      add("op3f",  mki(6'h3F, 4, 5, 16'h0001),    1, 0, 0, 0, 1, 1, 1, 16'h0,  1);
      add("lu_rt", mkr(10, 8, 9, 6'h20),          1, 0, 1, 8, 0, 0, 0, 16'h0,  0);
      add("lu_go", mkr(10, 8, 9, 6'h20),          1, 0, 0, 8, 1, 1, 1, c_rt,   0);
      add("lu_rs", mki(6'h2C, 8, 3, 16'h0004),    1, 0, 1, 8, 0, 0, 0, 16'h0,  0);
      add("r0",    mkr(0, 0, 9, 6'h20),           1, 0, 1, 0, 1, 1, 1, c_rt,   0);
      add("bgezrt",mki(6'h0D, 3, 8, 16'h0002),    1, 0, 1, 8, 1, 1, 1, c_bgez, 0);
      add("bnezrt",mki(6'h0C, 3, 8, 16'h0002),    1, 0, 1, 8, 1, 1, 1, c_bne,  0);
      add("jrrt",  mkr(3, 8, 0, 6'h08),           1, 0, 1, 8, 1, 1, 1, c_jr,   0);
      add("flhz",  mkr(10, 8, 9, 6'h20),          1, 1, 1, 8, 1, 1, 0, 16'h0,  0);
      add("flush", mki(6'h2C, 5, 6, 16'h0010),    1, 1, 0, 0, 1, 1, 0, 16'h0,  0);
      add("inv3f", mki(6'h3F, 4, 5, 16'h0001),    0, 0, 0, 0, 1, 1, 0, 16'h0,  0);
      add("invhz", mkr(10, 8, 9, 6'h20),          0, 0, 1, 8, 1, 1, 0, 16'h0,  0);

      // Reset held two cycles with a load presented and a hazard-shaped EX
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         rst = 1'b0; instr = mki(6'h2C, 8, 6, 16'h0010); ifid_valid = 1'b1;
         ex_memread = 1'b1; ex_rt = 5'd8; flush = 1'b0;
         #2;
         chk("rst.pc_write",   32'(pc_write),   32'd1);
         chk("rst.ifid_write", 32'(ifid_write), 32'd1);
         @(posedge clk);
         #1;
         chk("rst.valid",   32'(ex_valid),   32'd0);
         chk("rst.ctrl",    32'(got_ctrl()), 32'd0);
         chk("rst.illegal", 32'(ex_illegal), 32'd0);
         chk("rst.fields",  {ex_rs_q, ex_rt_q, ex_rd_q}, 32'd0);
         chk("rst.imm",     ex_imm, 32'd0);
      end
      drive_check("rst_rel", mki(6'h2C, 8, 6, 16'h0010), 1, 0, 0, 0, 1, 1, 1, c_lw, 0);

      foreach (vecs[i])
         drive_check(vecs[i].name, vecs[i].ins, vecs[i].v, vecs[i].fl, vecs[i].mr, vecs[i].er,
                     vecs[i].pcw, vecs[i].ifw, vecs[i].val, vecs[i].ctrl, vecs[i].ill);

`ifdef ID_STAGE_PERF_CNT_EN
      @(negedge clk); rst = 1'b0; @(posedge clk); #1;
      chk("cnt.rst_stall", stall_cnt, 32'd0);
      chk("cnt.rst_flush", flush_cnt, 32'd0);
      for (int i = 0; i < 3; i++)
         drive_check("cnt.stall", mkr(10, 8, 9, 6'h20), 1, 0, 1, 8, 0, 0, 0, 16'h0, 0);
      for (int i = 0; i < 2; i++)
         drive_check("cnt.flush", mkr(10, 11, 9, 6'h20), 1, 1, 0, 0, 1, 1, 0, 16'h0, 0);
      drive_check("cnt.norm", mkr(10, 11, 9, 6'h20), 1, 0, 0, 0, 1, 1, 1, c_rt, 0);
      chk("cnt.stall3", stall_cnt, 32'd3);
      chk("cnt.flush2", flush_cnt, 32'd2);
      @(negedge clk); rst = 1'b0; @(posedge clk); #1;
      chk("cnt.clr_stall", stall_cnt, 32'd0);
      chk("cnt.clr_flush", flush_cnt, 32'd0);
`endif

      // Random phase against the reference model
      ops = '{6'h00, 6'h08, 6'h2C, 6'h2D, 6'h0A, 6'h0B, 6'h0C, 6'h02, 6'h03, 6'h0E, 6'h0D, 6'h3F};
      for (int n = 0; n < 400; n++) begin
         sel = int'($urandom_range(0, 13));
         op  = (sel < 12) ? ops[sel] : 6'($urandom);
         fn  = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom);
         rs  = int'($urandom_range(0, 7));
         rt  = int'($urandom_range(0, 7));
         ins = {op, 5'(rs), 5'(rt), 16'($urandom)};
         ins[5:0] = fn;
         case ($urandom_range(0, 3))
            0:       er = 5'(rs);
            1:       er = 5'(rt);
            2:       er = 5'd0;
            default: er = 5'($urandom);
         endcase
         v  = ($urandom_range(0, 7) != 0);
         fl = ($urandom_range(0, 5) == 0);
         mr = 1'($urandom_range(0, 1));
         m  = model(ins, v, fl, mr, er);
         drive_check("rnd", ins, v, fl, mr, er, m.pcw, m.ifw, m.val, m.ctrl, m.ill);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_id_stage_ctrl
`default_nettype wire
